// File: rtl/nbp_pkg.sv
// Shared definitions for the parametrised one-bit NAND processor: FSM state codes,
// register address-map bases and instruction field offsets.
package nbp_pkg;

    typedef logic [1:0] nbp_state_t;

    localparam nbp_state_t ST_IDLE = 2'd0;
    localparam nbp_state_t ST_LOAD = 2'd1;
    localparam nbp_state_t ST_RUN  = 2'd2;
    localparam nbp_state_t ST_HALT = 2'd3;

    // Address 0 is the constant-1 register; inputs follow, then outputs, then internals.
    localparam int IN_BASE = 1;

    function automatic int out_base(int num_in);
        return IN_BASE + num_in;
    endfunction

    function automatic int int_base(int num_in, int num_out);
        return IN_BASE + num_in + num_out;
    endfunction

    localparam int FLD_A_LSB = 1;

    function automatic int fld_b_lsb(int aw);
        return aw + 1;
    endfunction

    function automatic int fld_d_lsb(int aw);
        return 2 * aw + 1;
    endfunction

    function automatic int fld_dir_bit(int aw);
        return aw + 1;
    endfunction

    function automatic int fld_off_lsb(int aw);
        return aw + 2;
    endfunction

endpackage

// File: rtl/nbp_loader.sv
// Serial program loader: assembles LSB-first instruction words, counts words into
// prog_len (saturating at DEPTH) and flags dropped words in a sticky prog_ovf.
module nbp_loader #(
    parameter  int IW    = 13,
    parameter  int DEPTH = 1024,
    localparam int PW    = $clog2(DEPTH),
    localparam int BW    = $clog2(IW)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          active,
    input  logic          prog_valid,
    input  logic          prog_bit,
    output logic          wr_en,
    output logic [PW-1:0] wr_addr,
    output logic [IW-1:0] wr_data,
    output logic [PW:0]   prog_len,
    output logic          prog_ovf
);

    localparam logic [PW:0]   FULL_LEN = DEPTH[PW:0];
    localparam logic [BW-1:0] LAST_BIT = BW'(IW - 1);
    localparam logic [PW:0]   LEN_ONE  = {{PW{1'b0}}, 1'b1};
    localparam logic [BW-1:0] CNT_ONE  = {{(BW-1){1'b0}}, 1'b1};

    logic [IW-2:0] shreg;
    logic [BW-1:0] bitcnt;
    logic          word_done;
    logic          full;

    assign full      = (prog_len == FULL_LEN);
    assign word_done = active && prog_valid && (bitcnt == LAST_BIT);
    assign wr_en     = word_done && !full;
    assign wr_addr   = prog_len[PW-1:0];
    // The final bit goes straight into the write data, so the word lands on this edge.
    assign wr_data   = {prog_bit, shreg};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            bitcnt   <= '0;
            prog_len <= '0;
            prog_ovf <= 1'b0;
        end else if (clear) begin
            bitcnt   <= '0;
            prog_len <= '0;
            prog_ovf <= 1'b0;
        end else if (active && prog_valid) begin
            if (bitcnt == LAST_BIT) begin
                bitcnt <= '0;
                if (full) prog_ovf <= 1'b1;
                else      prog_len <= prog_len + LEN_ONE;
            end else begin
                shreg[bitcnt] <= prog_bit;
                bitcnt        <= bitcnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/nand_bit_processor_p.sv
// Parametrised one-bit NAND processor with serial loader and IDLE/LOAD/RUN/HALT control.
// Optional NBP_SINGLE_STEP_EN adds a step input gating instruction commits in RUN.
module nand_bit_processor_p
    import nbp_pkg::*;
#(
    parameter  int NUM_IN     = 2,
    parameter  int NUM_OUT    = 7,
    parameter  int NUM_INT    = 6,
    parameter  int IMEM_DEPTH = 1024,
    localparam int NREG       = 1 + NUM_IN + NUM_OUT + NUM_INT,
    localparam int AW         = $clog2(NREG),
    localparam int IW         = 1 + 3 * AW,
    localparam int PW         = $clog2(IMEM_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IN-1:0]  in_reg,
    output logic [NUM_OUT-1:0] out_reg,
    input  logic               prog_mode,
    input  logic               prog_valid,
    input  logic               prog_bit,
    input  logic               run,
`ifdef NBP_SINGLE_STEP_EN
    input  logic               step,
`endif
    output logic               running,
    output logic               halted,
    output logic [PW-1:0]      pc,
    output logic [PW:0]        prog_len,
    output logic               prog_ovf
);

    localparam int OW       = 2 * AW - 1;
    localparam int RF       = 2 ** AW;
    localparam int OUT_BASE = out_base(NUM_IN);
    localparam int INT_BASE = int_base(NUM_IN, NUM_OUT);
    localparam int B_LSB    = fld_b_lsb(AW);
    localparam int D_LSB    = fld_d_lsb(AW);
    localparam int DIR_BIT  = fld_dir_bit(AW);
    localparam int OFF_LSB  = fld_off_lsb(AW);
    localparam logic [PW-1:0] PC_ONE = {{(PW-1){1'b0}}, 1'b1};

    nbp_state_t         state, state_nx;
    logic [PW-1:0]      pc_nx;
    logic [NUM_OUT-1:0] out_nx;
    logic [NUM_INT-1:0] int_reg, int_nx;
    logic [IW-1:0]      imem [IMEM_DEPTH];
    logic [IW-1:0]      instr;
    logic [RF-1:0]      rf;
    logic [AW-1:0]      fa, fb, fd;
    logic [OW-1:0]      off;
    logic [PW-1:0]      off_pw;
    logic               dir, rd_a, rd_b, nand_res, commit, exec_en;
    logic               ld_wr_en;
    logic [PW-1:0]      ld_wr_addr;
    logic [IW-1:0]      ld_wr_data;

`ifdef NBP_SINGLE_STEP_EN
    assign exec_en = step;
`else
    assign exec_en = 1'b1;
`endif

    nbp_loader #(.IW(IW), .DEPTH(IMEM_DEPTH)) u_loader (
        .clk        (clk),
        .reset      (reset),
        .clear      (prog_mode && (state != ST_LOAD)),
        .active     (prog_mode && (state == ST_LOAD)),
        .prog_valid (prog_valid),
        .prog_bit   (prog_bit),
        .wr_en      (ld_wr_en),
        .wr_addr    (ld_wr_addr),
        .wr_data    (ld_wr_data),
        .prog_len   (prog_len),
        .prog_ovf   (prog_ovf)
    );

    // NOTE: instruction memory has no reset; only words below prog_len are ever fetched.
    always_ff @(posedge clk) begin
        if (ld_wr_en) imem[ld_wr_addr] <= ld_wr_data;
    end

    assign instr    = imem[pc];
    assign fa       = instr[FLD_A_LSB +: AW];
    assign fb       = instr[B_LSB +: AW];
    assign fd       = instr[D_LSB +: AW];
    assign dir      = instr[DIR_BIT];
    assign off      = instr[OFF_LSB +: OW];
    assign off_pw   = PW'(off);

    // Flat read view of the address map; codes past the last register read 0.
    assign rf       = RF'({int_reg, out_reg, in_reg, 1'b1});
    assign rd_a     = rf[fa];
    assign rd_b     = rf[fb];
    assign nand_res = ~(rd_a & rd_b);

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        commit   = 1'b0;
        if (prog_mode) begin
            state_nx = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD: state_nx = ST_IDLE;
                ST_IDLE, ST_HALT: begin
                    if (run) begin
                        state_nx = ST_RUN;
                        pc_nx    = '0;
                    end
                end
                default: begin
                    if (exec_en) begin
                        if ({1'b0, pc} >= prog_len) begin
                            state_nx = ST_HALT;
                        end else if (instr[0]) begin
                            commit = 1'b1;
                            pc_nx  = pc + PC_ONE;
                        end else if (rd_a) begin
                            if (off == '0) state_nx = ST_HALT;
                            else           pc_nx    = dir ? (pc - off_pw) : (pc + off_pw);
                        end else begin
                            pc_nx = pc + PC_ONE;
                        end
                        if ((state_nx == ST_RUN) && ({1'b0, pc_nx} >= prog_len))
                            state_nx = ST_HALT;
                    end
                end
            endcase
        end
    end

    always_comb begin
        out_nx = out_reg;
        int_nx = int_reg;
        if (commit) begin
            for (int i = 0; i < NUM_OUT; i++)
                if (int'(fd) == OUT_BASE + i) out_nx[i] = nand_res;
            for (int i = 0; i < NUM_INT; i++)
                if (int'(fd) == INT_BASE + i) int_nx[i] = nand_res;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            pc      <= '0;
            out_reg <= '0;
            int_reg <= '0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            out_reg <= out_nx;
            int_reg <= int_nx;
        end
    end

    assign running = (state == ST_RUN);
    assign halted  = (state == ST_HALT);

endmodule

// File: tb/tb_nand_bit_processor_p.sv
// Self-checking bench for nand_bit_processor_p: random programs and inputs compared
// cycle by cycle against an instruction-level reference model.
module tb_nand_bit_processor_p;

    localparam int DEPTH = 1024;
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HALT = 3;

    logic        clk = 1'b0;
    logic        reset, prog_mode, prog_valid, prog_bit, run;
    logic [1:0]  in_reg;
    logic [6:0]  out_reg;
    logic        running, halted, prog_ovf;
    logic [9:0]  pc;
    logic [10:0] prog_len;
`ifdef NBP_SINGLE_STEP_EN
    logic        step;
`endif

    nand_bit_processor_p dut (
        .clk        (clk),
        .reset      (reset),
        .in_reg     (in_reg),
        .out_reg    (out_reg),
        .prog_mode  (prog_mode),
        .prog_valid (prog_valid),
        .prog_bit   (prog_bit),
        .run        (run),
`ifdef NBP_SINGLE_STEP_EN
        .step       (step),
`endif
        .running    (running),
        .halted     (halted),
        .pc         (pc),
        .prog_len   (prog_len),
        .prog_ovf   (prog_ovf)
    );

    always #5 clk = ~clk;

    int          ms, mpc, mlen;
    bit          movf;
    bit          mout [7];
    bit          mint [6];
    logic [12:0] mimem [DEPTH];
    int          checks = 0;
    int          passed = 0;
    bit          in_rand = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit mrd(int addr);
        if (addr == 0) return 1'b1;
        if (addr <= 2) return in_reg[addr-1];
        if (addr <= 9) return mout[addr-3];
        if (addr <= 15) return mint[addr-10];
        return 1'b0;
    endfunction

    task automatic mwr(int addr, bit v);
        if (addr >= 3 && addr <= 9) mout[addr-3] = v;
        else if (addr >= 10 && addr <= 15) mint[addr-10] = v;
    endtask

    task automatic model_reset();
        ms = M_IDLE; mpc = 0; mlen = 0; movf = 1'b0;
        foreach (mout[i]) mout[i] = 1'b0;
        foreach (mint[i]) mint[i] = 1'b0;
    endtask

    // Apply one clock edge of the architectural rules to the model.
    task automatic model_step();
        logic [12:0] w;
        int off;
        bit ex = 1'b1;
`ifdef NBP_SINGLE_STEP_EN
        ex = step;
`endif
        if (prog_mode) begin
            if (ms != M_LOAD) begin mlen = 0; movf = 1'b0; end
            ms = M_LOAD;
        end else if (ms == M_LOAD) begin
            ms = M_IDLE;
        end else if (ms == M_IDLE || ms == M_HALT) begin
            if (run) begin ms = M_RUN; mpc = 0; end
        end else if (ex) begin
            if (mpc >= mlen) begin
                ms = M_HALT;
            end else begin
                w = mimem[mpc];
                if (w[0]) begin
                    mwr(int'(w[12:9]), !(mrd(int'(w[4:1])) && mrd(int'(w[8:5]))));
                    mpc = (mpc + 1) % DEPTH;
                end else if (mrd(int'(w[4:1]))) begin
                    off = int'(w[12:6]);
                    if (off == 0) ms = M_HALT;
                    else if (w[5]) mpc = (mpc - off + DEPTH) % DEPTH;
                    else mpc = (mpc + off) % DEPTH;
                end else begin
                    mpc = (mpc + 1) % DEPTH;
                end
                if (ms == M_RUN && mpc >= mlen) ms = M_HALT;
            end
        end
    endtask

    task automatic compare_all();
        logic [6:0] exp_out;
        foreach (mout[i]) exp_out[i] = mout[i];
        check("out_reg", 32'(out_reg), 32'(exp_out));
        check("pc", 32'(pc), 32'(mpc));
        check("running", 32'(running), 32'(ms == M_RUN));
        check("halted", 32'(halted), 32'(ms == M_HALT));
        check("prog_len", 32'(prog_len), 32'(mlen));
        check("prog_ovf", 32'(prog_ovf), 32'(movf));
    endtask

    task automatic tick();
        if (in_rand) in_reg = 2'($urandom_range(0, 3));
`ifdef NBP_SINGLE_STEP_EN
        step = 1'($urandom_range(0, 1));
`endif
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic load_prog(input logic [12:0] words[$], input int extra);
        prog_valid = 1'b0;
        prog_mode  = 1'b1;
        tick();
        foreach (words[i]) begin
            for (int b = 0; b < 13; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    prog_valid = 1'b0;
                    tick();
                end
                prog_valid = 1'b1;
                prog_bit   = words[i][b];
                if (b == 12) begin
                    if (mlen == DEPTH) movf = 1'b1;
                    else begin mimem[mlen] = words[i]; mlen++; end
                end
                tick();
            end
        end
        for (int b = 0; b < extra; b++) begin
            prog_valid = 1'b1;
            prog_bit   = 1'($urandom_range(0, 1));
            tick();
        end
        prog_valid = 1'b0;
        prog_mode  = 1'b0;
        tick();
    endtask

    task automatic do_run(input int n);
        run = 1'b1;
        tick();
        run = 1'b0;
        repeat (n) tick();
    endtask

    function automatic logic [12:0] enc_nand(int a, int b, int d);
        return {d[3:0], b[3:0], a[3:0], 1'b1};
    endfunction

    function automatic logic [12:0] enc_br(int a, int dir, int off);
        return {off[6:0], dir[0], a[3:0], 1'b0};
    endfunction

    initial begin
        logic [12:0] q[$];
        reset = 1'b0; prog_mode = 1'b0; prog_valid = 1'b0; prog_bit = 1'b0;
        run = 1'b0; in_reg = 2'b00;
`ifdef NBP_SINGLE_STEP_EN
        step = 1'b1;
`endif
        model_reset();
        #3;
        compare_all();
        #9 reset = 1'b1;

        // NAND(const,const -> out0) then halt
        q = {enc_nand(0, 0, 3), enc_br(0, 0, 0)};
        load_prog(q, 0);
        do_run(3);

        // Toggle loop: out0 = ~out0, branch back by 1 on constant
        q = {enc_nand(3, 3, 3), enc_br(0, 1, 1)};
        load_prog(q, 0);
        do_run(20);

        // Forward branch on in_reg[0]
        in_rand = 1'b0;
        q = {enc_br(1, 0, 3), enc_nand(0, 0, 10), enc_nand(0, 0, 11),
             enc_nand(3, 3, 4), enc_br(0, 0, 0)};
        load_prog(q, 0);
        in_reg = 2'b00;
        do_run(6);
        in_reg = 2'b01;
        do_run(6);
        in_rand = 1'b1;

        // Random programs with random inputs
        repeat (6) begin
            int n;
            n = $urandom_range(3, 20);
            q = {};
            repeat (n) q.push_back(13'($urandom));
            load_prog(q, 0);
            do_run(40);
        end

        // prog_mode during RUN, then a partial word
        q = {enc_nand(3, 3, 3), enc_br(0, 1, 1)};
        load_prog(q, 0);
        do_run(5);
        q = {};
        load_prog(q, 5);
        check("partial_len", 32'(prog_len), 32'(0));
        do_run(2);

        // Asynchronous reset mid-run
        q = {enc_nand(3, 3, 3), enc_nand(3, 3, 12), enc_br(0, 1, 2)};
        load_prog(q, 0);
        do_run(7);
        #2 reset = 1'b0;
        model_reset();
        #1 compare_all();
        #1 reset = 1'b1;

        // Overflow: DEPTH+1 NAND-only words, then execution wraps modulo DEPTH
        q = {};
        repeat (DEPTH + 1) q.push_back(13'($urandom) | 13'h1);
        load_prog(q, 0);
        check("ovf_len", 32'(prog_len), 32'(DEPTH));
        check("ovf_flag", 32'(prog_ovf), 32'(1));
        do_run(DEPTH + 6);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/nand_bit_processor_p.md
# nand_bit_processor_p

Parametrised successor to the one-bit NAND processor: single-bit datapath, NAND as the only ALU operation, and relative branching on a register bit. Register counts, instruction memory depth and field widths are derived from parameters. Adds a defined serial program loader with overflow detection, an explicit IDLE/LOAD/RUN/HALT state machine, and a halt instruction. Program length is tracked, so execution past the loaded program halts. Sits at the project top level, between chip pads (inputs, outputs, serial program pin) and nothing else.

## Interface
- NUM_IN, 2, input register bits
- NUM_OUT, 7, output register bits
- NUM_INT, 6, internal register bits
- IMEM_DEPTH, 1024, instruction words; must be a power of two
- Derived, not overridable:
  - AW = clog2(1+NUM_IN+NUM_OUT+NUM_INT), register address width
  - IW = 1+3*AW, instruction width
  - PW = clog2(IMEM_DEPTH), PC width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; all state cleared while low
- in_reg  in  NUM_IN  external input bits, sampled combinationally on read
- out_reg  out  NUM_OUT  output register; reset 0
- prog_mode  in  1  level; high selects program load
- prog_valid  in  1  prog_bit valid this cycle
- prog_bit  in  1  serial instruction bit, LSB first
- run  in  1  single-cycle pulse; start execution at PC 0
- running  out  1  state==RUN; reset 0
- halted  out  1  state==HALT; reset 0
- pc  out  PW  current PC; reset 0
- prog_len  out  PW+1  words loaded; reset 0
- prog_ovf  out  1  sticky, words dropped past IMEM_DEPTH; reset 0

## Operation
- Register address map:
  - 0 = constant 1
  - 1..NUM_IN = in_reg
  - next NUM_OUT = out_reg
  - next NUM_INT = internal
  - unused codes read 0
  - writes to constant, input and unused addresses are ignored
- Instruction bit 0 = ctrl.
- NAND (ctrl=1):
  - fields [AW:1]=A, [2AW:AW+1]=B, [3AW:2AW+1]=D
  - reg[D] <= ~(reg[A] & reg[B]); PC+1
- Branch (ctrl=0):
  - fields [AW:1]=A, bit AW+1=dir, [3AW:AW+2]=offset (2AW-1 bits, unsigned)
  - if reg[A]==1: PC <= dir ? PC-offset : PC+offset; else PC+1
  - PC arithmetic is modulo 2^PW
- Halt: taken branch with offset 0 → HALT; PC holds.
- A PC value >= prog_len, whether reached on fetch or after an update, enters HALT without executing.
- States:
  - IDLE (reset)
  - LOAD
  - RUN
  - HALT
- Transitions:
  - any state with prog_mode=1 → LOAD. The loader clears its address and bit counter, prog_len and prog_ovf on entry.
  - LOAD with prog_mode=0 → IDLE. A partial word is discarded.
  - IDLE/HALT with run=1 → RUN, PC=0. Registers are not cleared.
  - RUN → HALT on a halt instruction or an out-of-range PC.
  - run is ignored in LOAD and RUN.
  - prog_mode has priority over run.
- Loader:
  - each prog_valid cycle shifts prog_bit into bit position bitcnt
  - at bitcnt==IW-1 the assembled word is written to imem[addr], addr++, prog_len++
  - at addr==IMEM_DEPTH further words are dropped and prog_ovf=1
  - prog_len saturates at IMEM_DEPTH
- imem is not reset; only words below prog_len are ever executed.

## Timing
- RUN: one instruction per clk. The instruction is fetched combinationally from imem[pc], and the register write plus PC update land on the same edge.
- run pulse at edge N: state=RUN after N. The first instruction commits at N+1.
- out_reg reflects a NAND result immediately after the executing edge.
- Loader: a word is visible in imem one edge after its IW-th valid bit.
- Reset assertion mid-load or mid-run clears to IDLE within the same cycle, asynchronously.

## Configuration
- NBP_SINGLE_STEP_EN defined: adds input step (1 bit). In RUN an instruction commits only on cycles with step=1; otherwise the state holds.
- Undefined: no step port; one instruction commits every cycle in RUN.

## Structure
- Package nbp_pkg holds:
  - state enum
  - address-map base constants (IN_BASE, OUT_BASE, INT_BASE)
  - opcode field offset functions of AW
- Sub-module nbp_loader: serial-to-parallel shifter, bit/word counters, prog_len, prog_ovf and imem write strobe.

## Test plan
- Reset low mid-RUN → out_reg=0, pc=0, running=0, halted=0 immediately.
- Load NAND(0,0→out0) then halt → after run: out_reg[0] toggles to 0 on cycle 1, halted=1 on cycle 2, pc=1.
- Loop: out0=~out0 with backward branch offset 1 on constant → out_reg[0] alternates every 2 cycles, never halts.
- Forward branch on in_reg[0]=0 not taken, =1 taken by 3 → pc sequence 0,1 vs 0,3.
- Load IMEM_DEPTH+1 words → prog_len=IMEM_DEPTH, prog_ovf=1. A program without halt halts at pc wrap to an index >= prog_len only if short, else loops modulo.
- prog_mode asserted during RUN → LOAD next cycle, prog_len=0. A partial 5-bit word then prog_mode low → prog_len unchanged.
